// File: rtl/tlb_array_pkg.sv
// Shared TLB definitions: geometry, entry layout, tlbp_bus layout and sweep state encodings.
// The optional invalidate sweeper is enabled with the TLB_INV_SWEEP_EN macro.
package tlb_array_pkg;

  localparam int TLBNUM      = 16;
  localparam int TLB_IW      = $clog2(TLBNUM);
  localparam int TLBP_BUS_WD = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  // tlbp_bus = {probe_valid, found, index}; write-back decodes the same layout.
  function automatic logic [TLBP_BUS_WD-1:0] pack_tlbp(input logic valid, input logic found,
                                                       input logic [TLB_IW-1:0] index);
    return {valid, found, index};
  endfunction

  function automatic tlb_page_t page_of(input tlb_entry_t e, input logic odd);
    tlb_page_t p;
    if (odd) p = '{pfn: e.pfn1, c: e.c1, d: e.d1, v: e.v1};
    else     p = '{pfn: e.pfn0, c: e.c0, d: e.d0, v: e.v0};
    return p;
  endfunction

endpackage

// File: rtl/tlb_array_match.sv
// Associative comparator plus lowest-index priority encoder; used for both searches and the probe.
// Valid bits deliberately take no part in matching.
module tlb_match #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0][18:0] vpn2,
  input  logic [N-1:0][7:0]  asid,
  input  logic [N-1:0]       g,
  input  logic [18:0]        q_vpn2,
  input  logic [7:0]         q_asid,
  output logic               found,
  output logic [IW-1:0]      index
);

  logic [N-1:0] hit;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      hit[i] = (vpn2[i] == q_vpn2) && (g[i] || (asid[i] == q_asid));
    end
  end

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && hit[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_array.sv
// Fully associative joint TLB: two search ports, TLBWI write, TLBR read, registered TLBP probe.
// TLB_INV_SWEEP_EN builds the invalidate sweeper; otherwise inv_req is ignored.
module tlb_array
  import tlb_array_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [18:0]            s0_vpn2,
  input  logic                   s0_odd_page,
  input  logic [7:0]             s0_asid,
  output logic                   s0_found,
  output logic [TLB_IW-1:0]      s0_index,
  output logic [19:0]            s0_pfn,
  output logic [2:0]             s0_c,
  output logic                   s0_d,
  output logic                   s0_v,
  input  logic [18:0]            s1_vpn2,
  input  logic                   s1_odd_page,
  input  logic [7:0]             s1_asid,
  output logic                   s1_found,
  output logic [TLB_IW-1:0]      s1_index,
  output logic [19:0]            s1_pfn,
  output logic [2:0]             s1_c,
  output logic                   s1_d,
  output logic                   s1_v,
  input  logic                   we,
  input  logic [TLB_IW-1:0]      w_index,
  input  logic [18:0]            w_vpn2,
  input  logic [7:0]             w_asid,
  input  logic                   w_g,
  input  logic [19:0]            w_pfn0,
  input  logic [2:0]             w_c0,
  input  logic                   w_d0,
  input  logic                   w_v0,
  input  logic [19:0]            w_pfn1,
  input  logic [2:0]             w_c1,
  input  logic                   w_d1,
  input  logic                   w_v1,
  input  logic [TLB_IW-1:0]      r_index,
  output logic [18:0]            r_vpn2,
  output logic [7:0]             r_asid,
  output logic                   r_g,
  output logic [19:0]            r_pfn0,
  output logic [2:0]             r_c0,
  output logic                   r_d0,
  output logic                   r_v0,
  output logic [19:0]            r_pfn1,
  output logic [2:0]             r_c1,
  output logic                   r_d1,
  output logic                   r_v1,
  input  logic                   tlbp_req,
  input  logic [18:0]            tlbp_vpn2,
  input  logic [7:0]             tlbp_asid,
  output logic [TLBP_BUS_WD-1:0] tlbp_bus,
  input  logic                   inv_req,
  output logic                   inv_busy,
  output sweep_state_e           sweep_state
);

  tlb_entry_t entries [TLBNUM];
  tlb_entry_t w_entry;

  logic [TLBNUM-1:0][18:0] vpn2_v;
  logic [TLBNUM-1:0][7:0]  asid_v;
  logic [TLBNUM-1:0]       g_v;

  logic              sweep_clr;
  logic [TLB_IW-1:0] sweep_idx;

  assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                     pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                     pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      vpn2_v[i] = entries[i].vpn2;
      asid_v[i] = entries[i].asid;
      g_v[i]    = entries[i].g;
    end
  end

  // A write to the slot being swept wins: the fresh entry is kept whole.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && (w_index == TLB_IW'(i))) begin
          entries[i] <= w_entry;
        end else if (sweep_clr && (sweep_idx == TLB_IW'(i))) begin
          entries[i].g  <= 1'b0;
          entries[i].v0 <= 1'b0;
          entries[i].v1 <= 1'b0;
          entries[i].d0 <= 1'b0;
          entries[i].d1 <= 1'b0;
        end
      end
    end
  end

  // Search ports
  logic      p_found;
  logic [TLB_IW-1:0] p_index;
  tlb_page_t s0_page, s1_page;

  tlb_match #(.N(TLBNUM), .IW(TLB_IW)) u_match_s0 (
    .vpn2(vpn2_v), .asid(asid_v), .g(g_v),
    .q_vpn2(s0_vpn2), .q_asid(s0_asid), .found(s0_found), .index(s0_index)
  );

  tlb_match #(.N(TLBNUM), .IW(TLB_IW)) u_match_s1 (
    .vpn2(vpn2_v), .asid(asid_v), .g(g_v),
    .q_vpn2(s1_vpn2), .q_asid(s1_asid), .found(s1_found), .index(s1_index)
  );

  tlb_match #(.N(TLBNUM), .IW(TLB_IW)) u_match_probe (
    .vpn2(vpn2_v), .asid(asid_v), .g(g_v),
    .q_vpn2(tlbp_vpn2), .q_asid(tlbp_asid), .found(p_found), .index(p_index)
  );

  assign s0_page = s0_found ? page_of(entries[s0_index], s0_odd_page) : '0;
  assign s1_page = s1_found ? page_of(entries[s1_index], s1_odd_page) : '0;

  assign {s0_pfn, s0_c, s0_d, s0_v} = s0_page;
  assign {s1_pfn, s1_c, s1_d, s1_v} = s1_page;

  assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
          r_pfn1, r_c1, r_d1, r_v1} = entries[r_index];

  always_ff @(posedge clk) begin
    if (reset)         tlbp_bus <= '0;
    else if (tlbp_req) tlbp_bus <= pack_tlbp(1'b1, p_found, p_index);
    else               tlbp_bus <= '0;
  end

`ifdef TLB_INV_SWEEP_EN
  sweep_state_e      state, state_nxt;
  logic [TLB_IW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (inv_req) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        if (cnt == TLB_IW'(TLBNUM - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sweep_clr   = (state == SWEEP);
  assign sweep_idx   = cnt;
  assign inv_busy    = sweep_clr;
  assign sweep_state = state;
`else
  logic unused_inv_req;
  assign unused_inv_req = inv_req;
  assign sweep_clr      = 1'b0;
  assign sweep_idx      = '0;
  assign inv_busy       = 1'b0;
  assign sweep_state    = IDLE;
`endif

endmodule
